// File: rtl/multi_channel_counter.sv
// NUM_CH independent up/down counters, each with a programmable terminal value,
// clear/load, and a wrap or saturate policy. All outputs are registered.
module multi_channel_counter #(
  parameter int NUM_CH       = 4,
  parameter int NUM_CNT_BITS = 8,
  parameter int SATURATE     = 0
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              count_down,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              wrap_pulse
);

  localparam int            W   = NUM_CNT_BITS;
  localparam bit            SAT = (SATURATE != 0);
  localparam logic [W-1:0]  ONE = W'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [W-1:0] r_cnt;
    logic         r_flag;
    logic         r_pulse;
    logic [W-1:0] w_rv;
    logic [W-1:0] w_lv;
    logic [W-1:0] w_inc;
    logic [W-1:0] w_dec;
    logic [W-1:0] w_term;
    logic [W-1:0] w_nxt;
    logic         w_ev;

    assign w_rv   = rollover_val[g*W +: W];
    assign w_lv   = load_val[g*W +: W];
    assign w_inc  = r_cnt + ONE;
    assign w_dec  = r_cnt - ONE;
    assign w_term = count_down[g] ? '0 : w_rv;

    // Priority clear > load > step > hold; only steps can raise an event.
    always_comb begin
      w_nxt = r_cnt;
      w_ev  = 1'b0;
      if (clear[g]) begin
        w_nxt = '0;
      end else if (load[g]) begin
        w_nxt = w_lv;
      end else if (count_enable[g]) begin
        if (!count_down[g]) begin
          if (r_cnt < w_rv) begin
            w_nxt = w_inc;
            w_ev  = SAT && (w_inc == w_rv);
          end else if (SAT) begin
            w_nxt = w_rv;
            w_ev  = (r_cnt != w_rv);
          end else begin
            w_nxt = '0;
            w_ev  = 1'b1;
          end
        end else begin
          if (r_cnt != '0) begin
            w_nxt = w_dec;
            w_ev  = SAT && (r_cnt == ONE);
          end else if (!SAT) begin
            w_nxt = w_rv;
            w_ev  = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        r_cnt   <= '0;
        r_flag  <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_cnt   <= w_nxt;
        r_flag  <= (w_nxt == w_term);
        r_pulse <= w_ev;
      end
    end

    assign count_out[g*W +: W] = r_cnt;
    assign rollover_flag[g]    = r_flag;
    assign wrap_pulse[g]       = r_pulse;
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Bench for multi_channel_counter: a wrap-mode and a saturate-mode instance share
// stimulus; directed scenarios plus randomized cycles against a behavioural model.
module tb_multi_channel_counter;
  localparam int NC = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            RST;
  logic [NC-1:0]   clear, load, count_enable, count_down;
  logic [NC*W-1:0] load_val, rollover_val;
  logic [NC*W-1:0] co_w, co_s;
  logic [NC-1:0]   rf_w, rf_s, wp_w, wp_s;

  int n_vec = 0;
  int n_err = 0;

  // Model state, index 0 = wrap instance, 1 = saturate instance
  int m_cnt [2][NC];
  bit m_flag[2][NC];
  bit m_pulse[2][NC];

  always #5 clk = ~clk;

  multi_channel_counter #(.NUM_CH(NC), .NUM_CNT_BITS(W), .SATURATE(0)) u_wrap (
    .clk(clk), .RST(RST), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .rollover_val(rollover_val),
    .count_out(co_w), .rollover_flag(rf_w), .wrap_pulse(wp_w));

  multi_channel_counter #(.NUM_CH(NC), .NUM_CNT_BITS(W), .SATURATE(1)) u_sat (
    .clk(clk), .RST(RST), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .rollover_val(rollover_val),
    .count_out(co_s), .rollover_flag(rf_s), .wrap_pulse(wp_s));

  task automatic model_zero();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NC; i++) begin
        m_cnt[s][i] = 0; m_flag[s][i] = 0; m_pulse[s][i] = 0;
      end
  endtask

  // One clock: evaluate the rules on the pre-edge inputs, commit at the edge.
  task automatic tick();
    int n [2][NC];
    bit ev[2][NC];
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NC; i++) begin
        int c, rv;
        c  = m_cnt[s][i];
        rv = int'(rollover_val[i*W +: W]);
        ev[s][i] = 0;
        if (clear[i]) n[s][i] = 0;
        else if (load[i]) n[s][i] = int'(load_val[i*W +: W]);
        else if (!count_enable[i]) n[s][i] = c;
        else if (!count_down[i]) begin
          if (c < rv) begin n[s][i] = c + 1; ev[s][i] = (s == 1) && (c + 1 == rv); end
          else if (s == 1) begin n[s][i] = rv; ev[s][i] = (c != rv); end
          else begin n[s][i] = 0; ev[s][i] = 1; end
        end else begin
          if (c > 0) begin n[s][i] = c - 1; ev[s][i] = (s == 1) && (c == 1); end
          else if (s == 1) n[s][i] = 0;
          else begin n[s][i] = rv; ev[s][i] = 1; end
        end
      end
    end
    @(posedge clk);
    if (RST) model_zero();
    else
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < NC; i++) begin
          m_cnt[s][i]   = n[s][i];
          m_pulse[s][i] = ev[s][i];
          m_flag[s][i]  = (n[s][i] == (count_down[i] ? 0 : int'(rollover_val[i*W +: W])));
        end
    #1;
  endtask

  task automatic idle_inputs();
    clear = '0; load = '0; count_enable = '0; count_down = '0;
    load_val = '0; rollover_val = '0;
  endtask

  task automatic test_reset();
    rollover_val[7:0] = 8'd5; count_enable[0] = 1'b1;
    repeat (3) tick();
    clear[0] = 1'b1; load[0] = 1'b1; load_val[7:0] = 8'd9;
    RST = 1'b1; model_zero(); #1;
    for (int k = 0; k < 2; k++) begin
      n_vec += 6;
      if (co_w !== '0) begin n_err++; $display("FAIL reset[%0d] co_w got %h want 0", k, co_w); end
      if (co_s !== '0) begin n_err++; $display("FAIL reset[%0d] co_s got %h want 0", k, co_s); end
      if (rf_w !== '0) begin n_err++; $display("FAIL reset[%0d] rf_w got %b want 0", k, rf_w); end
      if (rf_s !== '0) begin n_err++; $display("FAIL reset[%0d] rf_s got %b want 0", k, rf_s); end
      if (wp_w !== '0) begin n_err++; $display("FAIL reset[%0d] wp_w got %b want 0", k, wp_w); end
      if (wp_s !== '0) begin n_err++; $display("FAIL reset[%0d] wp_s got %b want 0", k, wp_s); end
      if (k == 0) tick();
    end
    RST = 1'b0;
    tick();
    n_vec += 2;
    if (co_w[7:0] !== 8'd0) begin n_err++; $display("FAIL clr_over_load co_w got %0d want 0", co_w[7:0]); end
    if (co_s[7:0] !== 8'd0) begin n_err++; $display("FAIL clr_over_load co_s got %0d want 0", co_s[7:0]); end
    clear[0] = 1'b0;
    tick();
    n_vec += 2;
    if (co_w[7:0] !== 8'd9) begin n_err++; $display("FAIL load_over_en co_w got %0d want 9", co_w[7:0]); end
    if (co_s[7:0] !== 8'd9) begin n_err++; $display("FAIL load_over_en co_s got %0d want 9", co_s[7:0]); end
    idle_inputs();
  endtask

  task automatic test_up_wrap();
    int ec[7] = '{1, 2, 3, 4, 5, 0, 1};
    int ef[7] = '{0, 0, 0, 0, 1, 0, 0};
    int ep[7] = '{0, 0, 0, 0, 0, 1, 0};
    int sc[7] = '{1, 2, 3, 4, 5, 5, 5};
    int sp[7] = '{0, 0, 0, 0, 1, 0, 0};
    clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    rollover_val[7:0] = 8'd5; count_enable[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_vec += 5;
      if (co_w[7:0] !== 8'(ec[k])) begin n_err++; $display("FAIL up_wrap[%0d] count got %0d want %0d", k, co_w[7:0], ec[k]); end
      if (rf_w[0] !== 1'(ef[k])) begin n_err++; $display("FAIL up_wrap[%0d] flag got %b want %0d", k, rf_w[0], ef[k]); end
      if (wp_w[0] !== 1'(ep[k])) begin n_err++; $display("FAIL up_wrap[%0d] pulse got %b want %0d", k, wp_w[0], ep[k]); end
      if (co_s[7:0] !== 8'(sc[k])) begin n_err++; $display("FAIL up_sat[%0d] count got %0d want %0d", k, co_s[7:0], sc[k]); end
      if (wp_s[0] !== 1'(sp[k])) begin n_err++; $display("FAIL up_sat[%0d] pulse got %b want %0d", k, wp_s[0], sp[k]); end
    end
    idle_inputs();
  endtask

  task automatic test_down_wrap();
    int ec[4] = '{1, 0, 7, 6};
    int ef[4] = '{0, 1, 0, 0};
    int ep[4] = '{0, 0, 1, 0};
    rollover_val[7:0] = 8'd7; count_down[0] = 1'b1;
    load[0] = 1'b1; load_val[7:0] = 8'd2; tick(); load[0] = 1'b0;
    count_enable[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec += 3;
      if (co_w[7:0] !== 8'(ec[k])) begin n_err++; $display("FAIL down_wrap[%0d] count got %0d want %0d", k, co_w[7:0], ec[k]); end
      if (rf_w[0] !== 1'(ef[k])) begin n_err++; $display("FAIL down_wrap[%0d] flag got %b want %0d", k, rf_w[0], ef[k]); end
      if (wp_w[0] !== 1'(ep[k])) begin n_err++; $display("FAIL down_wrap[%0d] pulse got %b want %0d", k, wp_w[0], ep[k]); end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    int uc[5] = '{1, 2, 3, 3, 3};
    int up[5] = '{0, 0, 1, 0, 0};
    int uf[5] = '{0, 0, 1, 1, 1};
    int dc[3] = '{1, 0, 0};
    int dp[3] = '{0, 1, 0};
    clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    rollover_val[7:0] = 8'd3; count_enable[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec += 3;
      if (co_s[7:0] !== 8'(uc[k])) begin n_err++; $display("FAIL sat_up[%0d] count got %0d want %0d", k, co_s[7:0], uc[k]); end
      if (wp_s[0] !== 1'(up[k])) begin n_err++; $display("FAIL sat_up[%0d] pulse got %b want %0d", k, wp_s[0], up[k]); end
      if (rf_s[0] !== 1'(uf[k])) begin n_err++; $display("FAIL sat_up[%0d] flag got %b want %0d", k, rf_s[0], uf[k]); end
    end
    count_enable[0] = 1'b0; count_down[0] = 1'b1;
    load[0] = 1'b1; load_val[7:0] = 8'd2; tick(); load[0] = 1'b0;
    count_enable[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec += 2;
      if (co_s[7:0] !== 8'(dc[k])) begin n_err++; $display("FAIL sat_down[%0d] count got %0d want %0d", k, co_s[7:0], dc[k]); end
      if (wp_s[0] !== 1'(dp[k])) begin n_err++; $display("FAIL sat_down[%0d] pulse got %b want %0d", k, wp_s[0], dp[k]); end
    end
    idle_inputs();
  endtask

  task automatic test_boundary();
    rollover_val[7:0] = 8'd10;
    load[0] = 1'b1; load_val[7:0] = 8'd200; tick(); load[0] = 1'b0;
    count_enable[0] = 1'b1; tick();
    n_vec += 5;
    if (co_w[7:0] !== 8'd0)  begin n_err++; $display("FAIL above_rv wrap count got %0d want 0", co_w[7:0]); end
    if (wp_w[0] !== 1'b1)    begin n_err++; $display("FAIL above_rv wrap pulse got %b want 1", wp_w[0]); end
    if (co_s[7:0] !== 8'd10) begin n_err++; $display("FAIL above_rv sat count got %0d want 10", co_s[7:0]); end
    if (wp_s[0] !== 1'b1)    begin n_err++; $display("FAIL above_rv sat pulse got %b want 1", wp_s[0]); end
    if (rf_s[0] !== 1'b1)    begin n_err++; $display("FAIL above_rv sat flag got %b want 1", rf_s[0]); end
    count_enable[0] = 1'b0; rollover_val[7:0] = 8'd0;
    clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    count_enable[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec += 5;
      if (co_w[7:0] !== 8'd0) begin n_err++; $display("FAIL rv0[%0d] wrap count got %0d want 0", k, co_w[7:0]); end
      if (wp_w[0] !== 1'b1)   begin n_err++; $display("FAIL rv0[%0d] wrap pulse got %b want 1", k, wp_w[0]); end
      if (rf_w[0] !== 1'b1)   begin n_err++; $display("FAIL rv0[%0d] wrap flag got %b want 1", k, rf_w[0]); end
      if (wp_s[0] !== 1'b0)   begin n_err++; $display("FAIL rv0[%0d] sat pulse got %b want 0", k, wp_s[0]); end
      if (rf_s[0] !== 1'b1)   begin n_err++; $display("FAIL rv0[%0d] sat flag got %b want 1", k, rf_s[0]); end
    end
    idle_inputs();
  endtask

  task automatic test_random_channels();
    for (int cyc = 0; cyc < 100; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        clear[i]        = ($urandom_range(0, 15) == 0);
        load[i]         = ($urandom_range(0, 7) == 0);
        count_enable[i] = ($urandom_range(0, 3) != 0);
        count_down[i]   = ($urandom_range(0, 2) == 0);
        load_val[i*W +: W]     = 8'($urandom_range(0, 255));
        rollover_val[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                             : 8'($urandom_range(0, 12));
      end
      tick();
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < NC; i++) begin
          logic [W-1:0] c;
          logic f, p;
          c = (s == 0) ? co_w[i*W +: W] : co_s[i*W +: W];
          f = (s == 0) ? rf_w[i] : rf_s[i];
          p = (s == 0) ? wp_w[i] : wp_s[i];
          n_vec += 3;
          if (c !== 8'(m_cnt[s][i])) begin n_err++; $display("FAIL rand c%0d m%0d ch%0d count got %0d want %0d", cyc, s, i, c, m_cnt[s][i]); end
          if (f !== m_flag[s][i])    begin n_err++; $display("FAIL rand c%0d m%0d ch%0d flag got %b want %b", cyc, s, i, f, m_flag[s][i]); end
          if (p !== m_pulse[s][i])   begin n_err++; $display("FAIL rand c%0d m%0d ch%0d pulse got %b want %b", cyc, s, i, p, m_pulse[s][i]); end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_zero();
    repeat (2) tick();
    RST = 1'b0;
    tick();
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_boundary();
    test_random_channels();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
